// File: rtl/enter_cmd_capture_if.sv
// ============================================================================
// Module   : enter_cmd_capture_if
// Purpose  : valid/ready command channel from the enter-capture block to the
//            processor control path (master = command source).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface enter_cmd_capture_if #(
  parameter int N_ACOES = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [N_ACOES-1:0] cmd_acoes;

  modport master (
    output cmd_valid,
    output cmd_acoes,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_acoes,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/enter_cmd_capture.sv
// ============================================================================
// Module   : enter_cmd_capture
// Purpose  : debounces the synchronized enter button and issues exactly one
//            captured action-switch command per physical press.
// Options  : define CMD_COUNT_EN to add the 16-bit accepted-command counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enter_cmd_capture #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int N_ACOES         = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enter_sync,
  input  logic                acoes_sync [0:N_ACOES-1],
  enter_cmd_capture_if.master cmd,
  output logic                busy
`ifdef CMD_COUNT_EN
  ,
  output logic [15:0]         cmd_count
`endif
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);

  // The sample that enters a debounce state is stable cycle 1, so the counter
  // only has to reach DEBOUNCE_CYCLES-2 on the edge of the final sample.
  localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 2);

  localparam logic [2:0] c_ST_IDLE       = 3'd0;
  localparam logic [2:0] c_ST_PRESS_DB   = 3'd1;
  localparam logic [2:0] c_ST_ISSUE      = 3'd2;
  localparam logic [2:0] c_ST_HOLD       = 3'd3;
  localparam logic [2:0] c_ST_RELEASE_DB = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_db_cnt;
  logic [N_ACOES-1:0] r_acoes;
  logic [N_ACOES-1:0] w_acoes_packed;
  logic               w_cmd_valid;
  logic               w_busy;
  logic               w_xfer;
  logic               w_db_done;
  logic               w_capture;

  for (genvar gi = 0; gi < N_ACOES; gi++) begin : g_pack_acoes
    assign w_acoes_packed[gi] = acoes_sync[gi];
  end

  assign w_xfer    = w_cmd_valid & cmd.cmd_ready;
  assign w_db_done = (r_db_cnt == c_DB_LAST);
  assign w_capture = (r_state == c_ST_PRESS_DB) && (w_state_nxt == c_ST_ISSUE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (enter_sync) w_state_nxt = c_ST_PRESS_DB;
      end
      c_ST_PRESS_DB: begin
        if (!enter_sync)    w_state_nxt = c_ST_IDLE;
        else if (w_db_done) w_state_nxt = c_ST_ISSUE;
      end
      c_ST_ISSUE: begin
        // Enter may be released here; the command still waits for its transfer.
        if (w_xfer) w_state_nxt = c_ST_HOLD;
      end
      c_ST_HOLD: begin
        if (!enter_sync) w_state_nxt = c_ST_RELEASE_DB;
      end
      c_ST_RELEASE_DB: begin
        if (enter_sync)     w_state_nxt = c_ST_HOLD;
        else if (w_db_done) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_cmd_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      c_ST_IDLE:  w_busy      = 1'b0;
      c_ST_ISSUE: w_cmd_valid = 1'b1;
      default:    ;
    endcase
  end

  // Debounce counter restarts on every state change and only runs while a
  // debounce state is being held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_db_cnt <= '0;
    end else if ((r_state == c_ST_PRESS_DB) || (r_state == c_ST_RELEASE_DB)) begin
      r_db_cnt <= r_db_cnt + c_CNT_W'(1);
    end
  end

  // Captured command is frozen until the next confirmed press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acoes <= '0;
    end else if (w_capture) begin
      r_acoes <= w_acoes_packed;
    end
  end

`ifdef CMD_COUNT_EN
  logic [15:0] r_cmd_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_count <= '0;
    end else if (w_xfer) begin
      r_cmd_count <= r_cmd_count + 16'd1;
    end
  end

  assign cmd_count = r_cmd_count;
`endif

  assign cmd.cmd_valid = w_cmd_valid;
  assign cmd.cmd_acoes = r_acoes;
  assign busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_enter_cmd_capture.sv
// ============================================================================
// Module   : tb_enter_cmd_capture
// Purpose  : self-checking bench for enter_cmd_capture with DEBOUNCE_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enter_cmd_capture;

  localparam int c_DB = 4;
  localparam int c_NA = 6;

  logic clk;
  logic reset;
  logic enter_sync;
  logic acoes_sync [0:c_NA-1];
  logic busy;
`ifdef CMD_COUNT_EN
  logic [15:0] cmd_count;
`endif

  enter_cmd_capture_if #(.N_ACOES(c_NA)) cmd_if ();

  enter_cmd_capture #(
    .DEBOUNCE_CYCLES (c_DB),
    .N_ACOES         (c_NA)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enter_sync (enter_sync),
    .acoes_sync (acoes_sync),
    .cmd        (cmd_if),
    .busy       (busy)
`ifdef CMD_COUNT_EN
    ,
    .cmd_count  (cmd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [c_NA-1:0] exp_q [$];
  logic [c_NA-1:0] obs_q [$];

  // Inputs change at posedge+2, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (!reset && cmd_if.cmd_valid && cmd_if.cmd_ready) obs_q.push_back(cmd_if.cmd_acoes);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_acoes(input logic [c_NA-1:0] v);
    for (int i = 0; i < c_NA; i++) acoes_sync[i] = v[i];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cmd_if.cmd_valid);
    else n_pass++;
    n_checks++;
    if (cmd_if.cmd_acoes !== 6'b000000) $display("FAIL reset_acoes: got %b want 000000", cmd_if.cmd_acoes);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
`ifdef CMD_COUNT_EN
    n_checks++;
    if (cmd_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", cmd_count);
    else n_pass++;
`endif
    reset = 1'b0;
    cyc(2);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_glitch;
    set_acoes(6'b111111);
    enter_sync = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      n_checks++;
      if (cmd_if.cmd_valid !== 1'b0 || busy !== 1'b1)
        $display("FAIL glitch_high%0d: valid=%b busy=%b want valid=0 busy=1", k, cmd_if.cmd_valid, busy);
      else n_pass++;
    end
    enter_sync = 1'b0;
    cyc(1);
    n_checks++;
    if (busy !== 1'b0 || cmd_if.cmd_valid !== 1'b0)
      $display("FAIL glitch_drop: busy=%b valid=%b want 0 0", busy, cmd_if.cmd_valid);
    else n_pass++;
    cyc(3);
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL glitch_no_cmd: transfers %0d want 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_press;
    logic [c_NA-1:0] e;
    logic [c_NA-1:0] o;
    // index 0..5 = 1,0,0,1,0,1 -> bit i = index i
    acoes_sync[0] = 1'b1; acoes_sync[1] = 1'b0; acoes_sync[2] = 1'b0;
    acoes_sync[3] = 1'b1; acoes_sync[4] = 1'b0; acoes_sync[5] = 1'b1;
    exp_q.push_back(6'b101001);
    enter_sync = 1'b1;
    for (int k = 1; k < c_DB; k++) begin
      cyc(1);
      n_checks++;
      if (cmd_if.cmd_valid !== 1'b0) $display("FAIL press_early%0d: valid got %b want 0", k, cmd_if.cmd_valid);
      else n_pass++;
    end
    cyc(1);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b1) $display("FAIL press_latency: valid got %b want 1", cmd_if.cmd_valid);
    else n_pass++;
    n_checks++;
    if (cmd_if.cmd_acoes !== 6'b101001) $display("FAIL press_acoes: got %b want 101001", cmd_if.cmd_acoes);
    else n_pass++;
    set_acoes(6'b010110);
    cyc(1);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b0) $display("FAIL press_one_cycle: valid got %b want 0", cmd_if.cmd_valid);
    else n_pass++;
    n_checks++;
    if (cmd_if.cmd_acoes !== 6'b101001) $display("FAIL press_retain: got %b want 101001", cmd_if.cmd_acoes);
    else n_pass++;
    cyc(5);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL press_xfer_count: got %0d want 1", obs_q.size());
    else begin
      o = obs_q.pop_front();
      if (o !== e) $display("FAIL press_scoreboard: got %b want %b", o, e);
      else n_pass++;
    end
    obs_q.delete();
    enter_sync = 1'b0;
    cyc(3);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL press_release3: busy got %b want 1", busy);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL press_release4: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [c_NA-1:0] e;
    logic [c_NA-1:0] o;
    cmd_if.cmd_ready = 1'b0;
    set_acoes(6'b010110);
    exp_q.push_back(6'b010110);
    enter_sync = 1'b1;
    cyc(c_DB);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", cmd_if.cmd_valid);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      set_acoes(c_NA'($urandom));
      cyc(1);
      n_checks++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_acoes !== 6'b010110)
        $display("FAIL bp_hold%0d: valid=%b acoes=%b want 1 010110", k, cmd_if.cmd_valid, cmd_if.cmd_acoes);
      else n_pass++;
    end
    enter_sync = 1'b0;
    cyc(1);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b1) $display("FAIL bp_release_keep: valid got %b want 1", cmd_if.cmd_valid);
    else n_pass++;
    cmd_if.cmd_ready = 1'b1;
    cyc(1);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b0) $display("FAIL bp_after_xfer: valid got %b want 0", cmd_if.cmd_valid);
    else n_pass++;
    cyc(4);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL bp_idle: busy got %b want 0", busy);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL bp_xfer_count: got %0d want 1", obs_q.size());
    else begin
      o = obs_q.pop_front();
      if (o !== e) $display("FAIL bp_scoreboard: got %b want %b", o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_hold_bounce;
    logic [c_NA-1:0] e;
    logic [c_NA-1:0] o;
    set_acoes(6'b111000);
    exp_q.push_back(6'b111000);
    enter_sync = 1'b1;
    cyc(100);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL hb_first_count: got %0d want 1", obs_q.size());
    else begin
      o = obs_q.pop_front();
      if (o !== e) $display("FAIL hb_first_scoreboard: got %b want %b", o, e);
      else n_pass++;
    end
    obs_q.delete();
    enter_sync = 1'b0; cyc(2);
    enter_sync = 1'b1; cyc(1);
    enter_sync = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      n_checks++;
      if (busy !== (k < 4))
        $display("FAIL hb_low%0d: busy got %b want %b", k, busy, (k < 4));
      else n_pass++;
    end
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL hb_bounce_extra: transfers %0d want 0", obs_q.size());
    else n_pass++;
    set_acoes(6'b000111);
    exp_q.push_back(6'b000111);
    enter_sync = 1'b1;
    cyc(c_DB);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b1) $display("FAIL hb_second_valid: got %b want 1", cmd_if.cmd_valid);
    else n_pass++;
    cyc(1);
    enter_sync = 1'b0;
    cyc(5);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL hb_second_count: got %0d want 1", obs_q.size());
    else begin
      o = obs_q.pop_front();
      if (o !== e) $display("FAIL hb_second_scoreboard: got %b want %b", o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_issue;
    cmd_if.cmd_ready = 1'b0;
    set_acoes(6'b110011);
    enter_sync = 1'b1;
    cyc(c_DB);
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b1) $display("FAIL rmi_valid: got %b want 1", cmd_if.cmd_valid);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (cmd_if.cmd_valid !== 1'b0 || cmd_if.cmd_acoes !== 6'b000000 || busy !== 1'b0)
      $display("FAIL rmi_async: valid=%b acoes=%b busy=%b want 0 000000 0",
               cmd_if.cmd_valid, cmd_if.cmd_acoes, busy);
    else n_pass++;
    enter_sync = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    n_checks++;
    if (busy !== 1'b0 || cmd_if.cmd_valid !== 1'b0 || obs_q.size() != 0)
      $display("FAIL rmi_idle: busy=%b valid=%b xfers=%0d want 0 0 0", busy, cmd_if.cmd_valid, obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

`ifdef CMD_COUNT_EN
  task automatic test_cmd_count;
    logic [c_NA-1:0] e;
    logic [c_NA-1:0] o;
    for (int p = 0; p < 3; p++) begin
      set_acoes(c_NA'(p + 9));
      exp_q.push_back(c_NA'(p + 9));
      enter_sync = 1'b1; cyc(c_DB + 1);
      enter_sync = 1'b0; cyc(5);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() != 1) $display("FAIL cnt_press%0d_count: got %0d want 1", p, obs_q.size());
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL cnt_press%0d_scoreboard: got %b want %b", p, o, e);
        else n_pass++;
      end
      obs_q.delete();
    end
    cmd_if.cmd_ready = 1'b0;
    enter_sync = 1'b1;
    cyc(c_DB);
    n_checks++;
    if (cmd_count !== 16'd3 || cmd_if.cmd_valid !== 1'b1)
      $display("FAIL cnt_pending: count=%0d valid=%b want 3 1", cmd_count, cmd_if.cmd_valid);
    else n_pass++;
    cmd_if.cmd_ready = 1'b1;
    cyc(1);
    n_checks++;
    if (cmd_count !== 16'd4) $display("FAIL cnt_after_ready: got %0d want 4", cmd_count);
    else n_pass++;
    enter_sync = 1'b0;
    cyc(5);
    obs_q.delete();
  endtask
`endif

  initial begin
    reset            = 1'b1;
    enter_sync       = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    set_acoes('0);
    test_reset();
    test_glitch();
    test_press();
    test_backpressure();
    test_hold_bounce();
    test_reset_mid_issue();
`ifdef CMD_COUNT_EN
    test_cmd_count();
`endif
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d commands never seen", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
